apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB4 master bridge that sits directly upstream of the uart_n APB slave port.
- Accepts simple read/write commands over a valid/ready interface and buffers them in a 2-entry command FIFO.
- Sequences each command through the APB SETUP/ACCESS phases and returns read data and error status over a valid/ready response channel.
- Lets firmware-side logic or a sequencer-driven wrapper program the UART's registers without hand-driving APB.

Parameters:
- ADDR_W, 12, width of cmd_addr/paddr in bits.
- DATA_W, 32, width of data buses; must be a multiple of 8.
- TIMEOUT_CYC, 255, ACCESS-phase cycles with pready=0 before abort (used only with APB_TIMEOUT_EN); range 1..65535.

Ports:
- clk  in  1  single system clock; also used as pclk.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command FIFO can accept.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_err  out  1  pslverr or timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB strobes.
- pready  in  1  slave ready.
- pslverr  in  1  slave error.
- prdata  in  DATA_W  slave read data.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset sampled on rising clk edge).
- Reset values: cmd_ready=0 while reset=1, else 1 when FIFO empty after reset. All other outputs are 0: rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata, pstrb.
- Reset flushes the FIFO and response register; the FSM returns to IDLE.
- Reset mid-transfer aborts the transfer: psel/penable are 0 on the cycle after the reset edge, and no response is produced.
- Command FIFO: depth 2. cmd_ready = !full.
  - Push on cmd_valid&&cmd_ready.
  - Simultaneous push and pop when full is not possible (ready=0). When 1 entry, both happen and the count is unchanged.
  - Read/write pointers wrap modulo 2.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when FIFO non-empty and response register empty (rsp_valid=0, or being consumed this cycle). The entry is popped and latched into the APB outputs.
  - SETUP: psel=1, penable=0, for exactly one cycle -> ACCESS.
  - ACCESS: psel=1, penable=1. paddr, pwrite, pwdata and pstrb are held stable.
  - ACCESS on pready=1: capture prdata (reads) or 0 (writes) into rsp_rdata, and pslverr into rsp_err. Set rsp_valid next cycle. psel=penable=0 -> IDLE.
  - pstrb is forced to 0 for reads. pwdata is forced to 0 for reads.
- No back-to-back SETUP: at least one IDLE cycle between transfers. psel is 0 in IDLE.
- Latency: command accepted at edge N -> SETUP during cycle N+1 -> ACCESS N+2 -> with pready=1 at edge N+3, rsp_valid=1 in cycle N+3.
- Response: rsp_valid holds with stable rsp_rdata/rsp_err until rsp_ready. It clears on handshake unless a new completion occurs the same edge; structurally impossible because a transfer only starts when the response register is free.
- Backpressure on rsp_ready stalls new APB transfers. The FIFO continues to accept commands until full.
- Commands are executed strictly in acceptance order.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0. When the count reaches TIMEOUT_CYC with pready still 0, the transfer ends: psel=penable=0 next cycle, rsp_err=1, rsp_rdata=0, FSM -> IDLE. pready=1 on the same cycle the count hits the limit counts as normal completion.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Write after reset: cmd write addr=0x004, wdata=0xA5, strb=0x1, pready=1 -> SETUP at N+1 with paddr=0x004, pwdata=0xA5, pstrb=0x1, pwrite=1; ACCESS at N+2; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read with wait states: read addr=0x008; slave holds pready=0 for 3 ACCESS cycles, then returns prdata=0x5A -> paddr stable all 4 ACCESS cycles; pstrb=0; rsp_rdata=0x5A.
- Slave error: write with pslverr=1 at completion -> rsp_err=1; next command proceeds normally.
- FIFO full / backpressure: hold rsp_ready=0 and issue 4 back-to-back commands -> first executes; 2 buffered; cmd_ready=0 on the 4th. Releasing rsp_ready drains them in order with one IDLE cycle between psel pulses.
- Reset mid-ACCESS: assert reset during ACCESS with pready=0 -> psel=penable=0 next cycle, no rsp_valid, cmd_ready=1 after reset drops.
- APB_TIMEOUT_EN, TIMEOUT_CYC=4, pready stuck at 0 -> after 4 ACCESS cycles, psel=0 and rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command FIFO (depth 2) feeding an APB4 master with a response register.
// Define APB_TIMEOUT_EN to abort ACCESS phases that see pready=0 for TIMEOUT_CYC cycles.
module apb_cmd_master #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [ADDR_W-1:0]   paddr,
   output logic [DATA_W-1:0]   pwdata,
   output logic [DATA_W/8-1:0] pstrb,
   input  logic                pready,
   input  logic                pslverr,
   input  logic [DATA_W-1:0]   prdata
);
   localparam int STRB_W = DATA_W / 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   logic              r_fifo_write [0:1];
   logic [ADDR_W-1:0] r_fifo_addr  [0:1];
   logic [DATA_W-1:0] r_fifo_wdata [0:1];
   logic [STRB_W-1:0] r_fifo_strb  [0:1];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;

   logic [1:0]        r_state;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [STRB_W-1:0] r_pstrb;

   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;

   logic              w_push;
   logic              w_pop;
   logic              w_complete;
   logic              w_timeout;
   logic              w_end;

   assign cmd_ready  = !reset && (r_count != 2'd2);
   assign w_push     = cmd_valid && cmd_ready;
   // A transfer starts only when its response will have somewhere to land.
   assign w_pop      = (r_state == ST_IDLE) && (r_count != 2'd0) && (!r_rsp_valid || rsp_ready);
   assign w_complete = (r_state == ST_ACCESS) && pready;
   assign w_end      = w_complete || w_timeout;

`ifdef APB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0] r_tcnt;

   always_ff @(posedge clk) begin
      if (reset || (r_state != ST_ACCESS)) begin
         r_tcnt <= '0;
      end else if (!pready) begin
         r_tcnt <= r_tcnt + 16'd1;
      end
   end

   assign w_timeout = (r_state == ST_ACCESS) && !pready && (r_tcnt == TO_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_write[r_wr_ptr] <= cmd_write;
         r_fifo_addr[r_wr_ptr]  <= cmd_addr;
         r_fifo_wdata[r_wr_ptr] <= cmd_wdata;
         r_fifo_strb[r_wr_ptr]  <= cmd_strb;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_psel    <= 1'b1;
                  r_penable <= 1'b0;
                  r_pwrite  <= r_fifo_write[r_rd_ptr];
                  r_paddr   <= r_fifo_addr[r_rd_ptr];
                  r_pwdata  <= r_fifo_write[r_rd_ptr] ? r_fifo_wdata[r_rd_ptr] : '0;
                  r_pstrb   <= r_fifo_write[r_rd_ptr] ? r_fifo_strb[r_rd_ptr] : '0;
                  r_state   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (w_end) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   // A timeout reports an error with zero data; a real completion reports the slave's status.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else if (w_end) begin
         r_rsp_valid <= 1'b1;
         r_rsp_rdata <= (w_complete && !r_pwrite) ? prdata : '0;
         r_rsp_err   <= w_complete ? pslverr : 1'b1;
      end else if (r_rsp_valid && rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pwrite    = r_pwrite;
   assign paddr     = r_paddr;
   assign pwdata    = r_pwdata;
   assign pstrb     = r_pstrb;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Testbench for apb_cmd_master: directed latency/corner steps plus randomized traffic
// against an in-order scoreboard and a behavioural APB slave with word memory.
module tb_apb_cmd_master;
   typedef struct packed {
      logic        write;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } apb_t;
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic        clk;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [11:0] paddr;
   logic [31:0] pwdata, prdata;
   logic [3:0]  pstrb;

   int   checks = 0;
   int   errors = 0;
   apb_t apb_q[$];
   rsp_t rsp_q[$];
   logic [31:0] refmem [0:1023];
   logic [31:0] smem   [0:1023];
   logic tb_stuck   = 1'b0;
   logic rand_waits = 1'b0;
   int   wait_cfg   = 0;
   logic acc_now;
   logic [3:0] r_top, r_idx;

   apb_cmd_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr), .prdata(prdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Scoreboard: every accepted command yields one APB transfer and one response, in order.
   task automatic model_accept();
      apb_t a;
      rsp_t r;
      int unsigned idx;
      logic err;
      idx = 32'(cmd_addr[11:2]);
      err = (cmd_addr[11:8] == 4'hF);
      a.write = cmd_write;
      a.addr  = cmd_addr;
      a.wdata = cmd_write ? cmd_wdata : 32'h0;
      a.strb  = cmd_write ? cmd_strb : 4'h0;
      if (tb_stuck) begin
         r.rdata = 32'h0;
         r.err   = 1'b1;
      end else if (cmd_write) begin
         r.rdata = 32'h0;
         r.err   = err;
         if (!err)
            for (int b = 0; b < 4; b++)
               if (cmd_strb[b]) refmem[idx][8*b +: 8] = cmd_wdata[8*b +: 8];
      end else begin
         r.rdata = refmem[idx];
         r.err   = err;
      end
      apb_q.push_back(a);
      rsp_q.push_back(r);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (!reset && cmd_valid && cmd_ready) model_accept();
      end
   end

   // Response checker: in-order compare on handshake, stability while stalled.
   logic        rc_held;
   logic [31:0] rc_rdata;
   logic        rc_err;
   rsp_t        rc_exp;
   initial begin
      rc_held = 1'b0;
      forever begin
         @(negedge clk);
         #4;
         if (reset) begin
            rc_held = 1'b0;
         end else begin
            if (rc_held) begin
               chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
               chk("rsp_hold_rdata", rsp_rdata, rc_rdata);
               chk("rsp_hold_err", 32'(rsp_err), 32'(rc_err));
            end
            if (rsp_valid && rsp_ready) begin
               rc_held = 1'b0;
               chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
               if (rsp_q.size() != 0) begin
                  rc_exp = rsp_q.pop_front();
                  $display("RSP rdata=%08h err=%0d (exp %08h/%0d)", rsp_rdata, rsp_err, rc_exp.rdata, rc_exp.err);
                  chk("rsp_rdata", rsp_rdata, rc_exp.rdata);
                  chk("rsp_err", 32'(rsp_err), 32'(rc_exp.err));
               end
            end else if (rsp_valid) begin
               rc_held  = 1'b1;
               rc_rdata = rsp_rdata;
               rc_err   = rsp_err;
            end else begin
               rc_held = 1'b0;
            end
         end
      end
   end

   // APB monitor: order of transfers, phase sequencing, idle gap and ACCESS stability.
   logic mon_psel, mon_pen;
   apb_t mon_exp, mon_lat;
   initial begin
      mon_psel = 1'b0;
      mon_pen  = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_psel = 1'b0;
            mon_pen  = 1'b0;
         end else begin
            if (psel && !penable) begin
               chk("apb_idle_gap", 32'(mon_psel), 32'd0);
               chk("apb_expected", 32'(apb_q.size() != 0), 32'd1);
               if (apb_q.size() != 0) begin
                  mon_exp = apb_q.pop_front();
                  chk("apb_paddr", 32'(paddr), 32'(mon_exp.addr));
                  chk("apb_pwrite", 32'(pwrite), 32'(mon_exp.write));
                  chk("apb_pwdata", pwdata, mon_exp.wdata);
                  chk("apb_pstrb", 32'(pstrb), 32'(mon_exp.strb));
               end
               mon_lat = '{write: pwrite, addr: paddr, wdata: pwdata, strb: pstrb};
            end else if (psel && penable) begin
               chk("apb_access_after_sel", 32'(mon_psel), 32'd1);
               chk("apb_stable", 32'({pwrite, paddr, pwdata, pstrb} == mon_lat), 32'd1);
            end else begin
               chk("apb_pen_idle", 32'(penable), 32'd0);
            end
            mon_psel = psel;
            mon_pen  = penable;
         end
      end
   end

   // Behavioural slave: wait states, address-decoded error region 0xFxx, byte-strobed memory.
   int   s_acc, s_wait;
   logic s_err;
   int unsigned s_idx;
   initial begin
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0; s_acc = 0; s_wait = 0;
      forever begin
         @(negedge clk);
         if (psel && penable) begin
            if (s_acc >= s_wait) begin
               s_err   = (paddr[11:8] == 4'hF);
               s_idx   = 32'(paddr[11:2]);
               pready  = 1'b1;
               pslverr = s_err;
               if (pwrite) begin
                  prdata = $urandom;
                  if (!s_err)
                     for (int b = 0; b < 4; b++)
                        if (pstrb[b]) smem[s_idx][8*b +: 8] = pwdata[8*b +: 8];
               end else begin
                  prdata = smem[s_idx];
               end
            end else begin
               pready  = 1'b0;
               pslverr = 1'($urandom_range(0, 1));
               prdata  = $urandom;
            end
            s_acc++;
         end else begin
            if (psel) begin
               s_acc  = 0;
               s_wait = rand_waits ? int'($urandom_range(0, 3)) : wait_cfg;
            end
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
         end
      end
   end

   task automatic drive(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_strb  = s;
   endtask

   task automatic wait_accept(input string tag);
      int n = 0;
      while (!cmd_ready && n < 200) begin
         tick();
         n++;
      end
      chk(tag, 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      drive(w, a, d, s);
      wait_accept("cmd_accept");
   endtask

   task automatic wait_rsp(input string tag);
      int n = 0;
      while (!rsp_valid && n < 200) begin
         tick();
         n++;
      end
      chk(tag, 32'(rsp_valid), 32'd1);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((rsp_q.size() != 0 || rsp_valid) && n < 3000) begin
         tick();
         n++;
      end
      chk(tag, 32'(rsp_q.size()), 32'd0);
      chk({tag, "_apb"}, 32'(apb_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         refmem[i] = 32'h0300_0000 + 32'(i) * 32'h11;
         smem[i]   = refmem[i];
      end
      refmem[2] = 32'h0000_005A;
      smem[2]   = 32'h0000_005A;

      repeat (3) tick();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_psel", 32'(psel), 32'd0);
      chk("rst_penable", 32'(penable), 32'd0);
      chk("rst_pwrite", 32'(pwrite), 32'd0);
      chk("rst_paddr", 32'(paddr), 32'd0);
      chk("rst_pwdata", pwdata, 32'd0);
      chk("rst_pstrb", 32'(pstrb), 32'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

      // Write after reset: exact SETUP/ACCESS/response latency.
      wait_cfg = 0;
      drive(1'b1, 12'h004, 32'h0000_00A5, 4'h1);
      tick();
      cmd_valid = 1'b0;
      chk("w1_idle_N", 32'(psel), 32'd0);
      tick();
      chk("w1_setup_psel", 32'(psel), 32'd1);
      chk("w1_setup_pen", 32'(penable), 32'd0);
      chk("w1_paddr", 32'(paddr), 32'h004);
      chk("w1_pwdata", pwdata, 32'h0000_00A5);
      chk("w1_pstrb", 32'(pstrb), 32'h1);
      chk("w1_pwrite", 32'(pwrite), 32'd1);
      tick();
      chk("w1_access", 32'(psel && penable), 32'd1);
      tick();
      chk("w1_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("w1_rsp_err", 32'(rsp_err), 32'd0);
      chk("w1_rsp_rdata", rsp_rdata, 32'd0);
      chk("w1_psel_off", 32'(psel), 32'd0);
      tick();

      // Read with three wait states.
      wait_cfg = 3;
      drive(1'b0, 12'h008, 32'hFFFF_FFFF, 4'hF);
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("r2_setup", 32'({psel, penable}), 32'b10);
      chk("r2_pstrb", 32'(pstrb), 32'd0);
      chk("r2_pwdata", pwdata, 32'd0);
      chk("r2_pwrite", 32'(pwrite), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("r2_access", 32'(psel && penable), 32'd1);
         chk("r2_paddr", 32'(paddr), 32'h008);
         chk("r2_rsp_pending", 32'(rsp_valid), 32'd0);
      end
      tick();
      chk("r2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("r2_rsp_rdata", rsp_rdata, 32'h0000_005A);
      tick();

      // Slave error, then a normal command.
      wait_cfg = 0;
      send(1'b1, 12'hF00, 32'h1234_5678, 4'hF);
      wait_rsp("e3_wait");
      chk("e3_rsp_err", 32'(rsp_err), 32'd1);
      tick();
      send(1'b0, 12'h008, 32'h0, 4'h0);
      wait_rsp("e3b_wait");
      chk("e3b_rsp_err", 32'(rsp_err), 32'd0);
      chk("e3b_rsp_rdata", rsp_rdata, 32'h0000_005A);
      tick();

      // FIFO full with response backpressure, then ordered drain.
      rsp_ready = 1'b0;
      drive(1'b1, 12'h010, 32'h1122_3344, 4'hF);
      tick();
      drive(1'b0, 12'h010, 32'h0, 4'h0);
      tick();
      drive(1'b1, 12'h014, 32'hAABB_CCDD, 4'h5);
      tick();
      drive(1'b0, 12'h014, 32'h0, 4'h0);
      chk("f4_full_ready", 32'(cmd_ready), 32'd0);
      repeat (5) tick();
      chk("f4_still_full", 32'(cmd_ready), 32'd0);
      chk("f4_stalled_psel", 32'(psel), 32'd0);
      chk("f4_rsp_held", 32'(rsp_valid), 32'd1);
      chk("f4_rsp_rdata_A", rsp_rdata, 32'd0);
      rsp_ready = 1'b1;
      wait_accept("f4_d_accept");
      drain("f4_drain");

      // Reset in the middle of a stalled ACCESS.
      wait_cfg = 1000;
      send(1'b0, 12'h020, 32'h0, 4'h0);
      n = 0;
      while (!(psel && penable) && n < 20) begin
         tick();
         n++;
      end
      chk("r5_in_access", 32'(psel && penable), 32'd1);
      tick();
      reset = 1'b1;
      apb_q.delete();
      rsp_q.delete();
      tick();
      chk("r5_psel", 32'(psel), 32'd0);
      chk("r5_penable", 32'(penable), 32'd0);
      chk("r5_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("r5_cmd_ready_rst", 32'(cmd_ready), 32'd0);
      reset = 1'b0;
      tick();
      chk("r5_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (3) tick();
      chk("r5_no_rsp", 32'(rsp_valid), 32'd0);
      wait_cfg = 0;
      send(1'b0, 12'h008, 32'h0, 4'h0);
      wait_rsp("r5_after_wait");
      chk("r5_after_rdata", rsp_rdata, 32'h0000_005A);
      tick();

`ifdef APB_TIMEOUT_EN
      // Slave stuck at pready=0: abort after four ACCESS cycles.
      wait_cfg = 1000;
      tb_stuck = 1'b1;
      send(1'b0, 12'h030, 32'h0, 4'h0);
      tb_stuck = 1'b0;
      n = 0;
      while (!(psel && penable) && n < 20) begin
         tick();
         n++;
      end
      chk("t6_access1", 32'(psel && penable), 32'd1);
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk("t6_access_n", 32'(psel && penable), 32'd1);
      end
      tick();
      chk("t6_psel", 32'(psel), 32'd0);
      chk("t6_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t6_rsp_err", 32'(rsp_err), 32'd1);
      chk("t6_rsp_rdata", rsp_rdata, 32'd0);
      tick();
      wait_cfg = 0;
`endif

      // Randomized traffic against the scoreboard.
      rand_waits = 1'b1;
      for (int i = 0; i < 400; i++) begin
         acc_now = cmd_valid && cmd_ready;
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
         if (acc_now || !cmd_valid) begin
            if ($urandom_range(0, 2) != 0) begin
               r_top = ($urandom_range(0, 7) == 0) ? 4'hF : 4'h0;
               r_idx = 4'($urandom_range(0, 15));
               drive(1'($urandom_range(0, 1)), {r_top, 2'b00, r_idx, 2'b00}, $urandom,
                     4'($urandom_range(0, 15)));
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      rsp_ready = 1'b1;
      if (cmd_valid) wait_accept("rand_last_accept");
      cmd_valid = 1'b0;
      drain("rand_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
